// File: rtl/freq_entry_ctrl.sv
// BCD frequency entry: digit editing from button pulses, then a digit-serial BCD-to-binary conversion.
// Define FREQ_CLAMP_EN to clamp results above MAX_FREQ and flag over_range; otherwise the result is truncated.
module freq_entry_ctrl #(
  parameter int DIGITS   = 7,
  parameter int OUT_W    = 23,
  parameter int MAX_FREQ = 5000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  commit,
  output logic [2:0]            cursor,
  output logic [4*DIGITS-1:0]   digits_bcd,
  output logic                  busy,
  output logic [OUT_W-1:0]      freq_out,
  output logic                  freq_valid,
  output logic                  over_range
);

  localparam int         ACC_W = 4 * DIGITS;
  localparam logic [2:0] LAST  = 3'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;

  state_e                 state_q, state_d;
  logic [DIGITS-1:0][3:0] digits_q, digits_d;
  logic [DIGITS-1:0][3:0] snap_q, snap_d;
  logic [2:0]             cursor_q, cursor_d;
  logic [2:0]             idx_q, idx_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [OUT_W-1:0]       freq_q, freq_d;
  logic                   over_q, over_d;
  logic                   valid_q, valid_d;

  logic                   edit_en, conv_en, load_en;
  logic [3:0]             cur_digit;
  logic [OUT_W-1:0]       res_freq;
  logic                   res_over;

  // ---------------------------------------------------------------- FSM
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit)        state_d = CONV;
      CONV:    if (idx_q == 3'd0) state_d = LOAD;
      LOAD:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    edit_en = 1'b0;
    conv_en = 1'b0;
    load_en = 1'b0;
    unique case (state_q)
      IDLE:    edit_en = 1'b1;
      CONV:    conv_en = 1'b1;
      LOAD:    load_en = 1'b1;
      default: edit_en = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- edits
  // Digit edit uses the cursor as it was this cycle; the cursor move lands afterwards.
  always_comb begin
    digits_d  = digits_q;
    cursor_d  = cursor_q;
    cur_digit = digits_q[cursor_q];
    if (edit_en) begin
      if (btn_up && !btn_down)
        digits_d[cursor_q] = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
      else if (btn_down && !btn_up)
        digits_d[cursor_q] = (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;

      if (btn_left && !btn_right)
        cursor_d = (cursor_q == LAST) ? 3'd0 : cursor_q + 3'd1;
      else if (btn_right && !btn_left)
        cursor_d = (cursor_q == 3'd0) ? LAST : cursor_q - 3'd1;
    end
  end

  // ---------------------------------------------------------------- conversion
  // Snapshot takes the post-edit digits so an edit in the commit cycle is included.
  always_comb begin
    snap_d = snap_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    if (edit_en && commit) begin
      snap_d = digits_d;
      acc_d  = '0;
      idx_d  = LAST;
    end else if (conv_en) begin
      acc_d = (acc_q << 3) + (acc_q << 1) + ACC_W'(snap_q[idx_q]);
      idx_d = idx_q - 3'd1;
    end
  end

`ifdef FREQ_CLAMP_EN
  always_comb begin
    if (acc_q > ACC_W'(MAX_FREQ)) begin
      res_freq = OUT_W'(MAX_FREQ);
      res_over = 1'b1;
    end else begin
      res_freq = acc_q[OUT_W-1:0];
      res_over = 1'b0;
    end
  end
`else
  localparam int unused_max_freq = MAX_FREQ;
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_q[ACC_W-1:OUT_W];
  assign res_freq      = acc_q[OUT_W-1:0];
  assign res_over      = 1'b0;
`endif

  always_comb begin
    freq_d  = freq_q;
    over_d  = over_q;
    valid_d = load_en;
    if (load_en) begin
      freq_d = res_freq;
      over_d = res_over;
    end
  end

  // ---------------------------------------------------------------- registers
  // NOTE: the snapshot and accumulator are small register banks, so they are reset like the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      cursor_q <= '0;
      snap_q   <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      freq_q   <= '0;
      over_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      digits_q <= digits_d;
      cursor_q <= cursor_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      freq_q   <= freq_d;
      over_q   <= over_d;
      valid_q  <= valid_d;
    end
  end

  assign cursor     = cursor_q;
  assign digits_bcd = digits_q;
  assign busy       = !edit_en;
  assign freq_out   = freq_q;
  assign freq_valid = valid_q;
  assign over_range = over_q;

endmodule

// File: doc/freq_entry_ctrl.md
# freq_entry_ctrl

Sequential front end for the function generator's frequency setting. It holds a 7-digit BCD frequency that is edited digit by digit from debounced buttons. On commit it converts the value to binary with a digit-serial multiply-by-10 accumulator, one digit per clock. It then range-checks the result and presents it to the phase-accumulator / DDS tuning stage with a one-cycle valid strobe.

## Interface
Parameters:
- DIGITS, 7, number of BCD digits edited and converted
- OUT_W, 23, width of binary frequency output
- MAX_FREQ, 5000000, highest legal frequency in Hz (used by clamp feature)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_left  input  1  one-cycle pulse, move cursor toward MSD
- btn_right  input  1  one-cycle pulse, move cursor toward LSD
- btn_up  input  1  one-cycle pulse, increment digit under cursor
- btn_down  input  1  one-cycle pulse, decrement digit under cursor
- commit  input  1  one-cycle pulse, start conversion of current digits
- cursor  output  3  index of selected digit, 0 = units
- digits_bcd  output  4*DIGITS  current edited digits, digit i at [4i+3:4i]
- busy  output  1  conversion in progress
- freq_out  output  OUT_W  last converted frequency, binary
- freq_valid  output  1  one-cycle strobe, freq_out updated
- over_range  output  1  last conversion exceeded MAX_FREQ

## Operation
- FSM states: IDLE, CONV, LOAD.
- IDLE handles edits:
  - btn_up: digit 9 wraps to 0.
  - btn_down: digit 0 wraps to 9.
  - btn_left: cursor DIGITS-1 wraps to 0.
  - btn_right: cursor 0 wraps to DIGITS-1.
- Simultaneous edit inputs:
  - up+down in the same cycle: no digit change.
  - left+right in the same cycle: no cursor change.
  - Digit edit plus cursor move: the edit applies at the old cursor, then the cursor moves.
- commit in IDLE:
  - Edits in that same cycle are applied first, then the edited digits are snapshotted.
  - Accumulator is cleared, digit index set to DIGITS-1, go to CONV.
- CONV:
  - Each cycle: acc <= (acc<<3) + (acc<<1) + snapshot[idx], MSD first.
  - acc width is 4*DIGITS bits; no overflow is possible.
  - After idx = 0 is consumed, go to LOAD.
- LOAD: register freq_out and over_range, pulse freq_valid, return to IDLE.
- busy = 1 in CONV and LOAD.
- While busy, all buttons and commit are ignored; they are not queued.
- digits_bcd stays editable only in IDLE; the snapshot isolates the conversion from edits.
- Reset values: cursor 0, all digits 0, busy 0, freq_out 0, freq_valid 0, over_range 0, state IDLE.
- rst_n asserted mid-conversion aborts immediately. No freq_valid is issued and all outputs take their reset values.

## Timing
- commit sampled at edge N → busy high from edge N.
- CONV occupies edges N+1 … N+DIGITS.
- LOAD at edge N+DIGITS+1: freq_out, over_range and freq_valid are updated. freq_valid is high for exactly one cycle.
- busy falls at the same edge N+DIGITS+1.
- Commit-to-valid latency is DIGITS+1 cycles (8 for default).
- The next commit is accepted at edge N+DIGITS+2 at the earliest.
- Edits in IDLE are visible on digits_bcd and cursor one cycle after the button pulse.
- freq_out holds its value between conversions.

## Configuration
- FREQ_CLAMP_EN defined:
  - If acc > MAX_FREQ, freq_out = MAX_FREQ and over_range = 1.
  - Otherwise freq_out = acc and over_range = 0.
- FREQ_CLAMP_EN undefined:
  - freq_out = acc[OUT_W-1:0], truncated.
  - over_range tied to 0.
  - MAX_FREQ is unused.

## Test plan
- Reset release → cursor 0, digits_bcd 0, freq_out 0, busy 0. Then commit → freq_valid after 8 cycles with freq_out = 0.
- Set units = 3, tens = 2, hundreds = 1 via up/left pulses, then commit → busy for 8 cycles, freq_out = 123, freq_valid one cycle wide.
- Wrap checks:
  - btn_down on digit 0 → 9.
  - btn_left at cursor 6 → 0.
  - btn_right at cursor 0 → 6.
  - up+down together → digit unchanged.
- All digits 9, commit:
  - With FREQ_CLAMP_EN: freq_out = 5000000, over_range = 1.
  - Without it: freq_out = 9999999 mod 2^23 = 1611391, over_range = 0.
- Digits 4999999, commit, then btn_up and a second commit during busy → freq_out = 4999999, only one freq_valid, digits_bcd unchanged.
- Commit, then pull rst_n low at cycle 4 of CONV → outputs at reset values, no freq_valid. After release, a fresh commit converts normally.
